// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared data-cache types: address split, frame, FSM states, constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int          DCACHE_NSETS = 8;
    localparam int          DCACHE_IDXW  = $clog2(DCACHE_NSETS);
    localparam int          DCACHE_TAGW  = 29 - DCACHE_IDXW;
    localparam logic [31:0] HITCNT_ADDR  = 32'h0000_3100;

    typedef struct packed {
        logic [DCACHE_TAGW-1:0] tag;
        logic [DCACHE_IDXW-1:0] idx;
        logic                   blkoff;
        logic [1:0]             bytoff;
    } dcachef_t;

    // Tag field is wide enough for any geometry; unused upper bits stay zero.
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [28:0]      tag;
        logic [1:0][31:0] data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, CNT, DONE
    } dcache_state_t;

endpackage

`default_nettype wire

// File: rtl/dcache.sv
// ============================================================================
// Module : dcache
// Brief  : Two-way set-associative write-back data cache with LL/SC and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache #(
    parameter int          NSETS       = 8,
    parameter logic [31:0] HITCNT_ADDR = cpu_types_pkg::HITCNT_ADDR
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    import cpu_types_pkg::*;

    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 29 - IDXW;
    localparam logic [IDXW:0] FLAST = (IDXW + 1)'(2 * NSETS - 1);

    dcache_state_t   r_state, w_next;
    dcache_frame_t   r_frm [2][NSETS];
    logic            r_lru [NSETS];
    logic [29:0]     r_link_addr;
    logic            r_link_valid;
    logic [31:0]     r_hitcnt;
    logic            r_missed;
    logic [IDXW:0]   r_fcnt;

    logic [TAGW-1:0] w_tag;
    logic [IDXW-1:0] w_idx;
    logic            w_off;
    logic [1:0]      w_wayhit;
    logic            w_hit, w_hway, w_vic;
    logic            w_link_match, w_sc, w_ll, w_scfail;
    dcache_frame_t   w_vframe, w_fframe;
    logic            w_fway;
    logic [IDXW-1:0] w_fset;
    logic            w_flast;
    logic            w_acc, w_fadv;
    logic            w_unused;

    assign w_tag    = dmemaddr[31:3+IDXW];
    assign w_idx    = dmemaddr[2+IDXW:3];
    assign w_off    = dmemaddr[2];
    assign w_unused = &{1'b0, dmemaddr[1:0]};

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            w_wayhit[w] = r_frm[w][w_idx].valid &&
                          (r_frm[w][w_idx].tag == {{IDXW{1'b0}}, w_tag});
        end
    end

    assign w_hit        = |w_wayhit;
    assign w_hway       = w_wayhit[1];
    assign w_vic        = r_lru[w_idx];
    assign w_vframe     = r_frm[w_vic][w_idx];
    assign w_link_match = r_link_valid && (r_link_addr == dmemaddr[31:2]);
    assign w_sc         = datomic & dmemWEN;
    assign w_ll         = datomic & dmemREN & ~dmemWEN;
    assign w_scfail     = w_sc & ~w_link_match;

    // Flush counter walks frames as {set, way}, way in the LSB.
    assign w_fway   = r_fcnt[0];
    assign w_fset   = r_fcnt[IDXW:1];
    assign w_fframe = r_frm[w_fway][w_fset];
    assign w_flast  = (r_fcnt == FLAST);
    assign flushed  = (r_state == DONE);

    always_comb begin
        w_next   = r_state;
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        w_acc    = 1'b0;
        w_fadv   = 1'b0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = FLUSH0;
                end else if (dmemREN || dmemWEN) begin
                    if (w_scfail) begin
                        dhit = 1'b1;
                    end else if (w_hit) begin
                        dhit  = 1'b1;
                        w_acc = 1'b1;
                        if (w_sc)
                            dmemload = 32'd1;
                        else if (!dmemWEN)
                            dmemload = r_frm[w_hway][w_idx].data[w_off];
                    end else begin
                        w_next = (w_vframe.valid && w_vframe.dirty) ? WB0 : FETCH0;
                    end
                end
            end
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {w_vframe.tag[TAGW-1:0], w_idx, (r_state == WB1), 2'b00};
                dstore = w_vframe.data[r_state == WB1];
                if (!dwait) w_next = (r_state == WB0) ? WB1 : FETCH0;
            end
            FETCH0, FETCH1: begin
                dREN  = 1'b1;
                daddr = {w_tag, w_idx, (r_state == FETCH1), 2'b00};
                if (!dwait) w_next = (r_state == FETCH0) ? FETCH1 : IDLE;
            end
            FLUSH0: begin
                if (w_fframe.valid && w_fframe.dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {w_fframe.tag[TAGW-1:0], w_fset, 3'b000};
                    dstore = w_fframe.data[0];
                    if (!dwait) w_next = FLUSH1;
                end else if (w_flast) begin
                    w_next = CNT;
                end else begin
                    w_fadv = 1'b1;
                end
            end
            FLUSH1: begin
                dWEN   = 1'b1;
                daddr  = {w_fframe.tag[TAGW-1:0], w_fset, 3'b100};
                dstore = w_fframe.data[1];
                if (!dwait) begin
                    if (w_flast) begin
                        w_next = CNT;
                    end else begin
                        w_fadv = 1'b1;
                        w_next = FLUSH0;
                    end
                end
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = r_hitcnt;
                if (!dwait) w_next = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_fcnt       <= '0;
            r_hitcnt     <= '0;
            r_missed     <= 1'b0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            for (int s = 0; s < NSETS; s++) begin
                r_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) r_frm[w][s] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_fadv) r_fcnt <= r_fcnt + 1'b1;
            if (r_state == IDLE && (w_next == WB0 || w_next == FETCH0)) r_missed <= 1'b1;
            if (dhit) r_missed <= 1'b0;
            if (w_acc) begin
                if (!r_missed) r_hitcnt <= r_hitcnt + 32'd1;
                r_lru[w_idx] <= ~w_hway;
                if (dmemWEN) begin
                    r_frm[w_hway][w_idx].data[w_off] <= dmemstore;
                    r_frm[w_hway][w_idx].dirty       <= 1'b1;
                end
                if (w_ll) begin
                    r_link_addr  <= dmemaddr[31:2];
                    r_link_valid <= 1'b1;
                end else if (dmemWEN && w_link_match) begin
                    r_link_valid <= 1'b0;
                end
            end
            if (r_state == FETCH0 && !dwait)
                r_frm[w_vic][w_idx].data[0] <= dload;
            if (r_state == FETCH1 && !dwait) begin
                r_frm[w_vic][w_idx].data[1] <= dload;
                r_frm[w_vic][w_idx].valid   <= 1'b1;
                r_frm[w_vic][w_idx].dirty   <= 1'b0;
                r_frm[w_vic][w_idx].tag     <= {{IDXW{1'b0}}, w_tag};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
// ============================================================================
// Module : tb_dcache
// Brief  : Self-checking bench for dcache against a set/way/LRU reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache;

    localparam int NS = 8;
    localparam int K_LW = 0, K_SW = 1, K_LL = 2, K_SC = 3;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0, halt = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic        dwait = 1'b0;
    logic [31:0] dload = '0;

    dcache dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } xfer_t;

    int          n_checks = 0, n_errors = 0;
    int          g_mode = 0;
    xfer_t       xq[$], eq[$];
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    bit          mv [NS][2], md [NS][2], ml [NS];
    logic [25:0] mt [NS][2];
    bit          m_lv;
    logic [29:0] m_la;
    int          m_hits;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'h1000_0000 ^ (a * 32'd2654435761);
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction
    function automatic logic [31:0] blk_addr(input logic [25:0] t, input int s, input int b);
        return {t, s[2:0], b[0], 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Memory side: decides dwait, serves reads, records completed transfers.
    task automatic tick();
        @(negedge CLK);
        #1;
        case (g_mode)
            1:       dwait = 1'b1;
            2:       dwait = 1'b0;
            default: dwait = ($urandom_range(0, 3) == 0);
        endcase
        dload = mem_rd(daddr);
        if (!dwait && dWEN) begin
            xq.push_back('{we: 1'b1, a: daddr, d: dstore});
            mem[daddr] = dstore;
        end
        if (!dwait && dREN) xq.push_back('{we: 1'b0, a: daddr, d: 32'h0});
        #1;
        if (dREN && dWEN) chk("onehot", {dREN, dWEN}, 32'h1);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            ml[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = '0; end
        end
        m_lv = 1'b0; m_la = '0; m_hits = 0;
        arch = mem;
    endtask

    task automatic model_access(input int k, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] ev, output bit eh);
        int          s, w;
        logic [25:0] t;
        logic [31:0] wa;
        bit          link_ok;
        s = int'(a[5:3]); t = a[31:6]; wa = {a[31:2], 2'b00};
        link_ok = m_lv && (m_la == a[31:2]);
        eq.delete(); ev = '0; eh = 1'b1;
        if (k == K_SC && !link_ok) return;
        if (mv[s][0] && mt[s][0] == t) w = 0;
        else if (mv[s][1] && mt[s][1] == t) w = 1;
        else begin
            w = int'(ml[s]); eh = 1'b0;
            if (mv[s][w] && md[s][w])
                for (int b = 0; b < 2; b++)
                    eq.push_back('{we: 1'b1, a: blk_addr(mt[s][w], s, b),
                                   d: arch_rd(blk_addr(mt[s][w], s, b))});
            for (int b = 0; b < 2; b++) eq.push_back('{we: 1'b0, a: blk_addr(t, s, b), d: 32'h0});
            mv[s][w] = 1'b1; md[s][w] = 1'b0; mt[s][w] = t;
        end
        if (eh) m_hits++;
        ml[s] = (w == 0);
        if (k == K_LW || k == K_LL) begin
            ev = arch_rd(wa);
            if (k == K_LL) begin m_lv = 1'b1; m_la = a[31:2]; end
        end else begin
            arch[wa] = d; md[s][w] = 1'b1;
            ev = (k == K_SC) ? 32'd1 : 32'd0;
            if (link_ok) m_lv = 1'b0;
        end
    endtask

    task automatic cmp_xfers(input string nm);
        chk({nm, ":ntx"}, xq.size(), eq.size());
        for (int i = 0; i < xq.size() && i < eq.size(); i++) begin
            chk({nm, ":we"}, {31'b0, xq[i].we}, {31'b0, eq[i].we});
            chk({nm, ":addr"}, xq[i].a, eq[i].a);
            if (eq[i].we) chk({nm, ":wdata"}, xq[i].d, eq[i].d);
        end
    endtask

    task automatic access(input int k, input logic [31:0] a, input logic [31:0] d, input string nm);
        logic [31:0] ev;
        bit          eh;
        int          n;
        model_access(k, a, d, ev, eh);
        xq.delete();
        dmemREN = (k == K_LW || k == K_LL); dmemWEN = (k == K_SW || k == K_SC);
        datomic = (k == K_LL || k == K_SC); dmemaddr = a; dmemstore = d;
        n = 0;
        do begin tick(); n++; end while (!dhit && n < 200);
        chk({nm, ":dhit"}, {31'b0, dhit}, 32'd1);
        if (k != K_SW) chk({nm, ":load"}, dmemload, ev);
        if (eh) chk({nm, ":latency"}, n, 32'd1);
        cmp_xfers(nm);
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          k;
        logic [31:0] a, last_ll;
        model_reset();
        last_ll = 32'h80;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst:dhit", {31'b0, dhit}, 0);     chk("rst:dREN", {31'b0, dREN}, 0);
        chk("rst:dWEN", {31'b0, dWEN}, 0);     chk("rst:daddr", daddr, 0);
        chk("rst:dstore", dstore, 0);          chk("rst:dmemload", dmemload, 0);
        chk("rst:flushed", {31'b0, flushed}, 0);
        @(posedge CLK); #1; nRST = 1'b1;

        // Stall in FETCH0, then reset during FETCH1
        dmemREN = 1'b1; dmemaddr = 32'h40;
        g_mode = 2; tick();
        g_mode = 1;
        repeat (5) begin
            tick();
            chk("stall:dREN", {31'b0, dREN}, 1); chk("stall:daddr", daddr, 32'h40);
            chk("stall:dhit", {31'b0, dhit}, 0);
        end
        g_mode = 2; tick();
        g_mode = 1; tick();
        chk("f1:dREN", {31'b0, dREN}, 1); chk("f1:daddr", daddr, 32'h44);
        nRST = 1'b0; #1;
        chk("midrst:dhit", {31'b0, dhit}, 0); chk("midrst:dREN", {31'b0, dREN}, 0);
        chk("midrst:dWEN", {31'b0, dWEN}, 0); chk("midrst:daddr", daddr, 0);
        chk("midrst:dstore", dstore, 0);      chk("midrst:dmemload", dmemload, 0);
        @(posedge CLK); #1;
        nRST = 1'b1; dmemREN = 1'b0; g_mode = 0;
        model_reset();

        // Directed scenarios
        access(K_LW, 32'h40, 0, "cold40");
        access(K_LW, 32'h44, 0, "hit44");
        access(K_SW, 32'h40, 32'hDEADBEEF, "sw40");
        access(K_LW, 32'h40, 0, "lw40");
        access(K_LW, 32'h240, 0, "lw240");
        access(K_LW, 32'h440, 0, "lw440");
        if (xq.size() > 0) chk("wb:first", xq[0].d, 32'hDEADBEEF);
        access(K_LL, 32'h80, 0, "ll80");
        access(K_SC, 32'h80, 32'h1111_2222, "sc80ok");
        access(K_LW, 32'h80, 0, "lw80a");
        access(K_LL, 32'h80, 0, "ll80b");
        access(K_SW, 32'h80, 32'h3333_4444, "sw80");
        access(K_SC, 32'h80, 32'h5555_6666, "sc80fail");
        access(K_LW, 32'h80, 0, "lw80b");
        access(K_SC, 32'h88, 32'h7777_8888, "scnoll");

        // Randomised traffic over a small, conflict-heavy address range
        for (int i = 0; i < 120; i++) begin
            k = int'($urandom_range(0, 3));
            a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if (k == K_SC && $urandom_range(0, 1) == 1) a = last_ll;
            if (k == K_LL) last_ll = a;
            access(k, a, $urandom, "rnd");
        end

        // Fresh cache: three dirty frames, five counted hits, then flush
        nRST = 1'b0; tick();
        chk("rst2:flushed", {31'b0, flushed}, 0);
        @(posedge CLK); #1; nRST = 1'b1;
        model_reset();
        access(K_SW, 32'h008, 32'hA0A0_0008, "fl:sw08");
        access(K_SW, 32'h010, 32'hA0A0_0010, "fl:sw10");
        access(K_SW, 32'h018, 32'hA0A0_0018, "fl:sw18");
        access(K_LW, 32'h008, 0, "fl:h1");
        access(K_LW, 32'h00C, 0, "fl:h2");
        access(K_LW, 32'h010, 0, "fl:h3");
        access(K_SW, 32'h014, 32'hB0B0_0014, "fl:h4");
        access(K_LW, 32'h018, 0, "fl:h5");

        eq.delete();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < 2; w++)
                if (mv[s][w] && md[s][w])
                    for (int b = 0; b < 2; b++)
                        eq.push_back('{we: 1'b1, a: blk_addr(mt[s][w], s, b),
                                       d: arch_rd(blk_addr(mt[s][w], s, b))});
        eq.push_back('{we: 1'b1, a: 32'h0000_3100, d: m_hits});
        xq.delete();
        halt = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!flushed && n < 500);
        chk("flush:flushed", {31'b0, flushed}, 1);
        chk("flush:count", xq.size(), 32'd7);
        if (xq.size() > 0) chk("flush:hitcnt", xq[xq.size()-1].d, 32'd5);
        cmp_xfers("flush");
        repeat (3) begin
            tick();
            chk("done:flushed", {31'b0, flushed}, 1);
            chk("done:idle", {30'b0, dREN, dWEN}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache.md
# dcache

Two-way set-associative, write-back, write-allocate data cache between the pipeline's memory stage and the memory controller. It consumes the memory stage's load/store/atomic requests, returns `dhit`/`dmemload`, and services misses over a word-serial memory port. It implements the LL/SC link register. On halt it writes back all dirty blocks plus the hit count, then raises `flushed`.

## Interface
- `NSETS`, 8, sets per way; power of two. Index width `IDXW = log2(NSETS)`.
- `HITCNT_ADDR`, 32'h0000_3100, word address that receives the hit count during flush.
- `CLK  in  1  clock`
- `nRST  in  1  reset, asynchronous, active-low`
- `dmemREN  in  1  load request (LW, LL)`
- `dmemWEN  in  1  store request (SW, SC)`
- `datomic  in  1  request is LL or SC`
- `dmemaddr  in  32  byte address; [1:0] ignored`
- `dmemstore  in  32  store data`
- `halt  in  1  pipeline halted; start flush`
- `dhit  out  1  request complete this cycle`
- `dmemload  out  32  load data; SC: 1 = success, 0 = fail`
- `flushed  out  1  flush and hit-count write complete (sticky until reset)`
- `dREN  out  1  memory read`
- `dWEN  out  1  memory write`
- `daddr  out  32  memory word address`
- `dstore  out  32  memory write data`
- `dwait  in  1  memory busy; transfer completes in the first cycle it is low`
- `dload  in  32  memory read data`

## Operation
- Address split: tag = `[31:3+IDXW]`; index = `[2+IDXW:3]`; block offset = `[2]` (two words per block); byte offset = `[1:0]`.
- Per frame: valid, dirty, tag, data[2]. Per set: one LRU bit that names the victim way. Any access that hits way w sets LRU to ~w.
- Read hit: `dhit`=1 and `dmemload`=word, combinationally, in IDLE.
- Write hit: `dhit`=1. At the clock edge the word is written, dirty=1, and LRU is updated.
- Miss: choose the victim way by LRU.
  - If the victim is valid and dirty: WB0 writes `{victag,idx,0,00}`, then WB1 writes `{victag,idx,1,00}`.
  - Then FETCH0 and FETCH1 read the new block. Data is written at each completing edge. Then valid=1, dirty=0, tag is updated.
  - The FSM returns to IDLE, and the request now hits.
- LL: behaves as a load. On completion, link ← {addr[31:2], valid=1}.
- SC:
  - Link valid and address match: performs a store, returns `dmemload`=1, clears link.
  - Otherwise: no cache or memory state changes, and `dmemload`=0 with `dhit`=1 in the same IDLE cycle. No miss is serviced.
- Any completed SW to the linked word clears link.
- Hit counter (32 bits): increments on every `dhit` in IDLE for a request that took no miss. A per-request `missed` flag is set on leaving IDLE for WB/FETCH and cleared on `dhit`. SC-fail does not count.
- FSM states: IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, CNT, DONE.
  - IDLE→FLUSH0: `halt`=1 and no request is being serviced. Halt has priority over a new request.
  - Flush iterates a {set, way} counter over 0..2·NSETS−1. Only valid and dirty frames are written (FLUSH0 writes word0, FLUSH1 writes word1). Clean frames are skipped at one frame per cycle.
  - After the last frame: CNT writes the hit count to `HITCNT_ADDR`, then DONE (`flushed`=1, terminal).
- Memory outputs hold stable while `dwait`=1. Only one of `dREN` and `dWEN` is ever high.

## Timing
- Reset (async) values:
  - Outputs: `dhit`=0, `dREN`=`dWEN`=0, `daddr`=`dstore`=0, `dmemload`=0, `flushed`=0.
  - Internal state: all valid/dirty/LRU=0, link invalid, hit count=0, FSM=IDLE, flush counter=0.
- Hit latency: 0 cycles (same cycle as the request).
- Clean miss: 2 memory transfers, then 1 IDLE hit cycle.
- Dirty miss: 4 memory transfers, then 1 IDLE hit cycle.
- `dhit` is never asserted outside IDLE. With no request in IDLE, memory outputs are 0.
- Reset asserted mid-miss or mid-flush: immediate return to reset state; partial block is discarded.
- `dmemREN` and `dmemWEN` both high: illegal; treat as a write.

## Structure
- Shared package `cpu_types_pkg` holds:
  - the `dcachef_t` address-split struct (tag/idx/blkoff/bytoff);
  - the `dcache_frame_t` struct;
  - the `dcache_state_t` enum;
  - the `HITCNT_ADDR` constant.
- Single module, no sub-modules. The frame arrays are flops, not SRAM.

## Test plan
- Cold LW 0x0000_0040:
  - Expect FETCH reads at 0x40 and 0x44.
  - Then `dhit`=1 with the loaded value.
  - A second LW to 0x44 hits in 0 cycles, and the hit count becomes 1.
- SW 0xDEADBEEF to 0x40, then LW 0x40 and LW 0x240 (same set, other way), then LW 0x440 (set full):
  - Victim is the LRU way holding 0x40.
  - Expect WB writes 0xDEADBEEF to 0x40, then its pair word to 0x44, then fetches of 0x440/0x444.
- LL 0x80 then SC 0x80 → `dmemload`=1 and the word is updated.
- LL 0x80, then SW 0x80, then SC 0x80 → `dmemload`=0 and the word is unchanged.
- SC with no prior LL → `dmemload`=0 and no memory traffic.
- Halt with 3 dirty frames, 5 hits:
  - Expect exactly 6 data writes in ascending {set, way} order.
  - Then a write of 5 to 0x3100.
  - Then `flushed`=1, holding.
- Hold `dwait`=1 for 5 cycles during FETCH0 → `daddr`/`dREN` stable and no `dhit`. Assert reset during FETCH1 → all outputs 0 and a later access misses.
